// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO: pointer/count widths and
// the wrap-aware pointer increment used for non-power-of-two depths.
package sync_fifo_pkg;

  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so any DEPTH works, not just powers of two.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo. The error-flag outputs
// exist only when FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
  parameter int WIDTH = 32
) ();

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

`ifdef FIFO_ERR_FLAGS_EN
  modport master (output wr_en, rd_en, data_in,
                  input  data_out, fifo_full, fifo_empty, overflow, underflow);
  modport slave  (input  wr_en, rd_en, data_in,
                  output data_out, fifo_full, fifo_empty, overflow, underflow);
`else
  modport master (output wr_en, rd_en, data_in,
                  input  data_out, fifo_full, fifo_empty);
  modport slave  (input  wr_en, rd_en, data_in,
                  output data_out, fifo_full, fifo_empty);
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage with one write port and one registered read port;
// kept separate so it can be replaced by a vendor RAM macro.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 9,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-before-write: a same-address write on this edge is not seen here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO control: circular pointers, occupancy counter and
// registered full/empty flags. Optional sticky error flags: FIFO_ERR_FLAGS_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 9
) (
  input  logic        clk,
  input  logic        resetn,
  sync_fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic             r_empty;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;

  // A write at full is still taken when a read frees the head slot.
  assign w_wr_acc = bus.wr_en && (!r_full || bus.rd_en);
  assign w_rd_acc = bus.rd_en && !r_empty;

  assign w_wptr_nxt = PTR_W'(ptr_next(int'(r_wptr), DEPTH));
  assign w_rptr_nxt = PTR_W'(ptr_next(int'(r_rptr), DEPTH));

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Flags track the next-state count so they change with the occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= w_wptr_nxt;
      if (w_rd_acc) r_rptr <= w_rptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data (bus.data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr),
    .o_rd_data (bus.data_out)
  );

  assign bus.fifo_full  = r_full;
  assign bus.fifo_empty = r_empty;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && r_full && !bus.rd_en) r_overflow  <= 1'b1;
      if (bus.rd_en && r_empty)              r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed table-driven bench for sync_fifo (WIDTH=32, DEPTH=9) with
// hand-written sequences for reset, streaming and mid-operation reset.
module tb_sync_fifo;

  logic clk;
  logic resetn;

  sync_fifo_if #(.WIDTH(32)) bus ();

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (9)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic        full;
    logic        empty;
  } vec_t;

  vec_t tv[$];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic rd, input logic [31:0] din,
                              input logic [31:0] dout, input logic full, input logic empty);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.full = full; v.empty = empty;
    tv.push_back(v);
  endfunction

  // Drive inputs just after a rising edge, then sample 1 unit after the next one.
  task automatic step(input logic wr, input logic rd, input logic [31:0] din);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] dout,
                           input logic full, input logic empty);
    chk({tag, ".dout"},  bus.data_out,   dout);
    chk({tag, ".full"},  32'(bus.fifo_full),  32'(full));
    chk({tag, ".empty"}, 32'(bus.fifo_empty), 32'(empty));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    resetn      = 1'b0;

    // Fill 0..10: full after the 9th write, 9 and 10 dropped.
    for (int k = 0; k <= 10; k++) add(1'b1, 1'b0, 32'(k), 32'h0, (k >= 8), 1'b0);
    // Drain 11 reads: 0..8, then data_out holds 8.
    for (int k = 0; k <= 10; k++) add(1'b0, 1'b1, 32'h0, (k <= 8) ? 32'(k) : 32'd8, 1'b0, (k >= 8));
    // Empty with both: write only, no fall-through.
    add(1'b1, 1'b1, 32'h33, 32'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0,  32'h33, 1'b0, 1'b1);
    // Refill with 10..18, try a write at full, then read+write at full.
    for (int k = 0; k < 9; k++) add(1'b1, 1'b0, 32'(10 + k), 32'h33, (k == 8), 1'b0);
    add(1'b1, 1'b0, 32'hDEAD, 32'h33, 1'b1, 1'b0);
    add(1'b1, 1'b1, 32'hA5,   32'd10, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 32'h0, 32'(11 + k), 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0, 32'hA5, 1'b0, 1'b1);

    // Reset held for 2 cycles, then 5 idle cycles.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 32'h0, 1'b0, 1'b1);
    resetn = 1'b1;
    repeat (5) step(1'b0, 1'b0, 32'h0);
    check_out("idle", 32'h0, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_reset", 32'(bus.overflow),  32'h0);
    chk("unf_reset", 32'(bus.underflow), 32'h0);
`endif

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].wr, tv[i].rd, tv[i].din);
      check_out($sformatf("vec%0d", i), tv[i].dout, tv[i].full, tv[i].empty);
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(bus.overflow),  32'h1);
    chk("unf_set", 32'(bus.underflow), 32'h1);
`endif

    // Streaming from empty over 3+ pointer wraps.
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b1, 32'(100 + k));
      check_out($sformatf("stream%0d", k), (k == 0) ? 32'hA5 : 32'(100 + k - 1), 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 32'h0);
    check_out("stream_tail", 32'(129), 1'b0, 1'b1);

    // Mid-operation reset with 5 words queued (one already popped).
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h100 + 32'(k));
    step(1'b0, 1'b1, 32'h0);
    check_out("pre_rst", 32'h100, 1'b0, 1'b0);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_clr", 32'(bus.overflow),  32'h0);
    chk("unf_clr", 32'(bus.underflow), 32'h0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 32'h55);
    check_out("post_wr", 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0);
    check_out("post_rd", 32'h55, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-in first-out buffer with a parameterised data width and entry count.
- Registered read data, plus full and empty status flags.
- Used as a generic elastic buffer between producer and consumer logic in the same clock domain inside the app template.
- Storage is an inferable RAM/register array with circular read and write pointers.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 9, number of storage entries (>=2); non-power-of-two values are supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- wr_en  input  1  write request; data_in is stored on the edge if accepted.
- rd_en  input  1  read request; head word is popped to data_out on the edge if accepted.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  registered read data.
- fifo_full  output  1  high when occupancy == DEPTH.
- fifo_empty  output  1  high when occupancy == 0.

Behaviour:
- Reset (resetn low, asynchronous assert, release synchronous to clk):
  - write pointer = 0, read pointer = 0, occupancy = 0.
  - data_out = 0, fifo_empty = 1, fifo_full = 0.
- Storage contents are not reset.
- Write acceptance: wr_accept = wr_en && (!fifo_full || rd_en).
- Read acceptance: rd_accept = rd_en && !fifo_empty.
- Accepted write:
  - mem[wptr] <= data_in.
  - wptr advances; wraps from DEPTH-1 to 0 explicitly (no reliance on power-of-two overflow).
- Accepted read:
  - data_out <= mem[rptr] on the same edge, so data is visible one cycle after rd_en is sampled.
  - rptr advances with the same wrap rule.
- data_out holds its last value when no read is accepted.
- Occupancy counter, width $clog2(DEPTH+1): +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- fifo_full and fifo_empty are registered, derived from the next-state occupancy, and valid in the same cycle the occupancy changes.
- Boundary conditions:
  - Full with wr_en only: write ignored, contents unchanged, no error.
  - Full with wr_en and rd_en: both accepted; occupancy stays DEPTH; fifo_full stays 1.
  - Empty with rd_en only: read ignored; data_out holds.
  - Empty with wr_en and rd_en: write accepted, read ignored (no fall-through); occupancy becomes 1.
  - Pointer wrap-around is exact at DEPTH entries for any DEPTH.
- Reset asserted mid-operation: all pointers and flags return to reset values immediately; queued data is discarded.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are present, each 1 bit:
  - overflow: sticky, set when wr_en is high while full and rd_en is low.
  - underflow: sticky, set when rd_en is high while empty.
- Both flags are cleared only by resetn.
- When undefined, these ports and their logic are absent; the core behaviour is identical in both cases.

Decomposition:
- fifo_pkg holds:
  - function clog2-based pointer width (PTR_W = max(1, $clog2(DEPTH))).
  - count width (CNT_W = $clog2(DEPTH+1)).
  - a pointer-increment-with-wrap function.
- One natural sub-module, fifo_mem:
  - single write port, single registered read port, WIDTH x DEPTH.
  - holds the storage array so it can be swapped for a vendor RAM.
- Control (pointers, counter, flags) stays in sync_fifo.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> data_out=0, fifo_empty=1, fifo_full=0; release; idle 5 cycles -> unchanged.
- Fill (WIDTH=32, DEPTH=9): write 0..10 with rd_en=0 -> fifo_full rises after the 9th write; values 9 and 10 dropped; fifo_empty=0.
- Drain: then rd_en=1 for 11 cycles -> data_out sequence 0..8, one cycle after each read; fifo_empty=1 after the 9th read; data_out holds 8 afterward.
- Streaming: wr_en=rd_en=1 continuously with data_in=0,1,2,... from empty -> data_out follows in order with 2-cycle latency from write; occupancy never exceeds 1; no loss across 3 pointer wraps (30 words).
- Full with simultaneous read/write: at full, assert both with data_in=0xA5 -> head popped, 0xA5 stored, fifo_full stays 1; later drain returns 0xA5 last.
- Mid-operation reset: 5 words queued, pulse resetn low asynchronously -> immediate fifo_empty=1, data_out=0; next write/read pair returns the new word.
  - With FIFO_ERR_FLAGS_EN defined: the overflow and underflow cases above set the sticky flags; reset clears them.
